// File: rtl/cpu_pkg.sv
// Shared CPU constants: default address width, NOP encoding and sequential
// fetch stride.
package cpu_pkg;
  localparam int XLEN = 32;
  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam int PC_INC = 4;
endpackage

// File: rtl/if_slot_buf.sv
// Circular fetch-slot store: each slot holds a PC, an instruction word and a
// filled flag; head pops, tail allocates, fill points at the oldest unfilled slot.
module if_slot_buf #(
  parameter int XLEN  = cpu_pkg::XLEN,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   alloc,
  input  logic [XLEN-1:0]        alloc_pc,
  input  logic                   fill,
  input  logic [31:0]            fill_instr,
  input  logic                   pop,
  output logic                   head_valid,
  output logic [XLEN-1:0]        head_pc,
  output logic [31:0]            head_instr,
  output logic [$clog2(DEPTH):0] count
);
  import cpu_pkg::*;

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [XLEN-1:0]  pc_mem    [DEPTH];
  logic [31:0]      instr_mem [DEPTH];
  logic [DEPTH-1:0] filled;
  logic [PW-1:0]    head_q;
  logic [PW-1:0]    tail_q;
  logic [PW-1:0]    fill_q;
  logic [CW-1:0]    count_q;

  // Pointers are PW bits wide, so DEPTH being a power of two gives free wrap.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      head_q  <= '0;
      tail_q  <= '0;
      fill_q  <= '0;
      count_q <= '0;
      filled  <= '0;
    end else begin
      if (alloc) begin
        filled[tail_q] <= 1'b0;
        tail_q         <= tail_q + 1'b1;
      end
      if (fill) begin
        filled[fill_q] <= 1'b1;
        fill_q         <= fill_q + 1'b1;
      end
      if (pop) begin
        head_q <= head_q + 1'b1;
      end
      count_q <= count_q + CW'(alloc) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (alloc) begin
      pc_mem[tail_q] <= alloc_pc;
    end
    if (fill) begin
      instr_mem[fill_q] <= fill_instr;
    end
  end

  assign head_valid = (count_q != '0) && filled[head_q];
  assign head_pc    = (count_q != '0) ? pc_mem[head_q] : '0;
  assign head_instr = head_valid ? instr_mem[head_q] : NOP;
  assign count      = count_q;
endmodule

// File: rtl/if_prefetch_unit.sv
// Instruction prefetch unit: issues sequential fetches into a small slot
// buffer, returns words in order to decode, and discards stale responses on redirect.
module if_prefetch_unit #(
  parameter int XLEN  = cpu_pkg::XLEN,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [XLEN-1:0]        boot_addr,
  input  logic                   redirect_valid,
  input  logic [XLEN-1:0]        redirect_pc,
  output logic                   imem_req_valid,
  input  logic                   imem_req_ready,
  output logic [XLEN-1:0]        imem_req_addr,
  input  logic                   imem_rsp_valid,
  input  logic [31:0]            imem_rsp_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [XLEN-1:0]        out_pc,
  output logic [31:0]            out_instr,
  output logic [$clog2(DEPTH):0] occupancy
);
  import cpu_pkg::*;

  localparam int CW = $clog2(DEPTH) + 1;
  // Headroom for responses still owed across several back-to-back redirects.
  localparam int OW = CW + 3;

  logic [XLEN-1:0] pc_q;
  logic [OW-1:0]   outst_q;
  logic [OW-1:0]   discard_q;
  logic            full;
  logic            req_fire;
  logic            rsp_fire;
  logic            rsp_drop;
  logic            rsp_keep;
  logic            pop;
  logic            head_valid;
  logic [XLEN-1:0] head_pc;
  logic [31:0]     head_instr;
  logic [CW-1:0]   count;

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; valid never depends on ready, and a stalled entry holds its data.
  assign full           = (count == CW'(DEPTH));
  assign imem_req_valid = !rst && !redirect_valid && !full;
  assign imem_req_addr  = rst ? boot_addr : pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;
  assign rsp_fire       = imem_rsp_valid && (outst_q != '0) && !rst;
  assign rsp_drop       = rsp_fire && (redirect_valid || (discard_q != '0));
  assign rsp_keep       = rsp_fire && !rsp_drop;
  assign out_valid      = head_valid && !redirect_valid && !rst;
  assign pop            = out_valid && out_ready;
  assign out_pc         = rst ? '0 : head_pc;
  assign out_instr      = rst ? '0 : head_instr;
  assign occupancy      = count;

  if_slot_buf #(
    .XLEN (XLEN),
    .DEPTH(DEPTH)
  ) u_slot_buf (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect_valid),
    .alloc     (req_fire),
    .alloc_pc  (pc_q),
    .fill      (rsp_keep),
    .fill_instr(imem_rsp_data),
    .pop       (pop),
    .head_valid(head_valid),
    .head_pc   (head_pc),
    .head_instr(head_instr),
    .count     (count)
  );

  // On redirect every still-owed response becomes stale; no request fires that
  // cycle, so the new outstanding count equals the new discard count.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q      <= boot_addr;
      outst_q   <= '0;
      discard_q <= '0;
    end else begin
      outst_q <= outst_q + OW'(req_fire) - OW'(rsp_fire);
      if (redirect_valid) begin
        pc_q      <= redirect_pc;
        discard_q <= outst_q - OW'(rsp_fire);
      end else begin
        if (req_fire) begin
          pc_q <= pc_q + XLEN'(PC_INC);
        end
        if (rsp_drop) begin
          discard_q <= discard_q - 1'b1;
        end
      end
    end
  end
endmodule
